// File: rtl/cascade_inta_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cascade_inta_seq
//  Purpose  : INTA sequencer for an 8259-style PIC. It follows the two-pulse
//             8086 interrupt-acknowledge cycle. As master it drives the CAS
//             bus with the serviced IR level. As slave it decides whether the
//             CAS bus selects this device. It issues the ISR-set, freeze,
//             vector-enable and AEOI strobes to the priority/ISR stages.
//  Ports    : CLK, RSTn          clock (rising edge), async active-low reset
//             INTAn              CPU acknowledge, active low, synchronous
//             SPENn, buff, MS    role selection (master = buff ? MS : SPENn)
//             sngl, icw3_m       single mode / master cascade map
//             slave_id           slave cascade identity
//             int_pend,irq_level resolver request and its IR level
//             aeoi               automatic end-of-interrupt mode
//             CAS_in             sampled CAS bus
//             CAS_out, CAS_oe    CAS value and enable when acting as master
//             freeze             hold IRR/priority during the acknowledge
//             isr_set, aeoi_clr  one-cycle ISR set / clear strobes
//             vec_oe, vec_level  vector enable and latched IR level
//             abort              one-cycle strobe, 2nd INTA never arrived
//  Revision : 1.0  initial release
// ============================================================================
module cascade_inta_seq #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       INTAn,
  input  logic       SPENn,
  input  logic       buff,
  input  logic       MS,
  input  logic       sngl,
  input  logic [7:0] icw3_m,
  input  logic [2:0] slave_id,
  input  logic       int_pend,
  input  logic [2:0] irq_level,
  input  logic       aeoi,
  input  logic [2:0] CAS_in,
  output logic [2:0] CAS_out,
  output logic       CAS_oe,
  output logic       freeze,
  output logic       isr_set,
  output logic       vec_oe,
  output logic [2:0] vec_level,
  output logic       aeoi_clr,
  output logic       abort
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK2 = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic             prev_q,      prev_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             master_q,    master_d;
  logic             pend_q,      pend_d;
  logic [2:0]       vec_level_q, vec_level_d;
  logic [2:0]       cas_out_q,   cas_out_d;
  logic             cas_oe_q,    cas_oe_d;
  logic             freeze_q,    freeze_d;
  logic             isr_set_q,   isr_set_d;
  logic             vec_oe_q,    vec_oe_d;
  logic             aeoi_clr_q,  aeoi_clr_d;
  logic             abort_q,     abort_d;

  logic       fall;
  logic       rise;
  logic       role_master;
  logic [2:0] ack_level;

  assign fall        = !INTAn &&  prev_q;
  assign rise        =  INTAn && !prev_q;
  assign role_master = buff ? MS : SPENn;
  // With nothing pending the acknowledge is spurious and reports IR7.
  assign ack_level   = int_pend ? irq_level : 3'd7;

  always_comb begin
    state_d     = state_q;
    prev_d      = INTAn;
    cnt_d       = cnt_q;
    master_d    = master_q;
    pend_d      = pend_q;
    vec_level_d = vec_level_q;
    cas_out_d   = cas_out_q;
    cas_oe_d    = cas_oe_q;
    freeze_d    = freeze_q;
    vec_oe_d    = vec_oe_q;
    isr_set_d   = 1'b0;
    aeoi_clr_d  = 1'b0;
    abort_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d     = ST_ACK1;
          master_d    = role_master;
          pend_d      = int_pend;
          vec_level_d = ack_level;
          freeze_d    = 1'b1;
          if (role_master) begin
            isr_set_d = int_pend;
            if (!sngl && icw3_m[ack_level]) begin
              cas_out_d = ack_level;
              cas_oe_d  = 1'b1;
            end
          end
        end
      end

      ST_ACK1: begin
        if (rise) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end

      ST_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall) begin
          state_d = ST_ACK2;
          if (master_q) begin
            // A cascaded slave supplies the vector for its own IR line.
            vec_oe_d = sngl || !icw3_m[vec_level_q];
          end else if (CAS_in == slave_id) begin
            // The request latched at the first pulse decides the ISR set,
            // so a spurious acknowledge never marks a level in service.
            isr_set_d = pend_q;
            vec_oe_d  = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          abort_d  = 1'b1;
          freeze_d = 1'b0;
          cas_oe_d = 1'b0;
        end
      end

      ST_ACK2: begin
        if (rise) begin
          state_d    = ST_IDLE;
          aeoi_clr_d = aeoi && vec_oe_q && pend_q;
          vec_oe_d   = 1'b0;
          cas_oe_d   = 1'b0;
          freeze_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      master_q    <= 1'b0;
      pend_q      <= 1'b0;
      vec_level_q <= 3'd0;
      cas_out_q   <= 3'd0;
      cas_oe_q    <= 1'b0;
      freeze_q    <= 1'b0;
      isr_set_q   <= 1'b0;
      vec_oe_q    <= 1'b0;
      aeoi_clr_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      master_q    <= master_d;
      pend_q      <= pend_d;
      vec_level_q <= vec_level_d;
      cas_out_q   <= cas_out_d;
      cas_oe_q    <= cas_oe_d;
      freeze_q    <= freeze_d;
      isr_set_q   <= isr_set_d;
      vec_oe_q    <= vec_oe_d;
      aeoi_clr_q  <= aeoi_clr_d;
      abort_q     <= abort_d;
    end
  end

  assign CAS_out   = cas_out_q;
  assign CAS_oe    = cas_oe_q;
  assign freeze    = freeze_q;
  assign isr_set   = isr_set_q;
  assign vec_oe    = vec_oe_q;
  assign vec_level = vec_level_q;
  assign aeoi_clr  = aeoi_clr_q;
  assign abort     = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_cascade_inta_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cascade_inta_seq
//  Purpose  : Self-checking bench for cascade_inta_seq. An event-level model
//             counts the INTAn edges of each acknowledge and predicts every
//             output. Directed literal checks pin that model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cascade_inta_seq;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic       CLK = 1'b0;
  logic       RSTn, INTAn, SPENn, buff, MS, sngl, int_pend, aeoi;
  logic [7:0] icw3_m;
  logic [2:0] slave_id, irq_level, CAS_in;
  logic [2:0] CAS_out, vec_level;
  logic       CAS_oe, freeze, isr_set, vec_oe, aeoi_clr, abort;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit rnd_en = 1'b0;

  always #5 CLK = ~CLK;

  cascade_inta_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .INTAn(INTAn), .SPENn(SPENn), .buff(buff),
    .MS(MS), .sngl(sngl), .icw3_m(icw3_m), .slave_id(slave_id),
    .int_pend(int_pend), .irq_level(irq_level), .aeoi(aeoi),
    .CAS_in(CAS_in), .CAS_out(CAS_out), .CAS_oe(CAS_oe), .freeze(freeze),
    .isr_set(isr_set), .vec_oe(vec_oe), .vec_level(vec_level),
    .aeoi_clr(aeoi_clr), .abort(abort)
  );

  // Reference model. m_edges is the number of INTAn edges seen so far in
  // the current acknowledge: 0 none, 1 first low, 2 between pulses,
  // 3 second low. m_gap counts cycles spent between the pulses.
  int         m_edges = 0;
  int         m_gap   = 0;
  logic       m_prev = 1'b1, m_master = 1'b0, m_pend = 1'b0;
  logic       m_cas_oe = 1'b0, m_vec_oe = 1'b0, m_freeze = 1'b0;
  logic       m_isr = 1'b0, m_aeoi = 1'b0, m_abort = 1'b0;
  logic [2:0] m_lvl = 3'd0, m_cas = 3'd0;
  logic       fell, rose;

  function automatic logic routed_to_slave(input logic [2:0] l);
    logic [7:0] map;
    map = icw3_m;
    return !sngl && map[l];
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_edges = 0; m_gap = 0; m_prev = 1'b1; m_master = 1'b0; m_pend = 1'b0;
      m_cas_oe = 1'b0; m_vec_oe = 1'b0; m_freeze = 1'b0; m_isr = 1'b0;
      m_aeoi = 1'b0; m_abort = 1'b0; m_lvl = 3'd0; m_cas = 3'd0;
    end else begin
      fell   = m_prev && !INTAn;
      rose   = !m_prev && INTAn;
      m_prev = INTAn;
      m_isr = 1'b0; m_aeoi = 1'b0; m_abort = 1'b0;
      if (m_edges == 0 && fell) begin
        m_edges  = 1;
        m_master = buff ? MS : SPENn;
        m_pend   = int_pend;
        m_lvl    = int_pend ? irq_level : 3'd7;
        m_freeze = 1'b1;
        if (m_master) begin
          m_isr = int_pend;
          if (routed_to_slave(m_lvl)) begin
            m_cas    = m_lvl;
            m_cas_oe = 1'b1;
          end
        end
      end else if (m_edges == 1 && rose) begin
        m_edges = 2;
        m_gap   = 0;
      end else if (m_edges == 2) begin
        m_gap = m_gap + 1;
        if (fell) begin
          m_edges = 3;
          if (m_master) m_vec_oe = !routed_to_slave(m_lvl);
          else if (CAS_in == slave_id) begin
            m_vec_oe = 1'b1;
            m_isr    = m_pend;
          end
        end else if (m_gap == TIMEOUT) begin
          m_edges  = 0;
          m_abort  = 1'b1;
          m_freeze = 1'b0;
          m_cas_oe = 1'b0;
        end
      end else if (m_edges == 3 && rose) begin
        m_edges  = 0;
        m_aeoi   = aeoi && m_vec_oe && m_pend;
        m_vec_oe = 1'b0;
        m_cas_oe = 1'b0;
        m_freeze = 1'b0;
      end
    end
  end

  // Every-cycle comparison of the whole output set against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      checks++;
      if ({CAS_out, CAS_oe, freeze, isr_set, vec_oe, vec_level, aeoi_clr, abort} !==
          {m_cas, m_cas_oe, m_freeze, m_isr, m_vec_oe, m_lvl, m_aeoi, m_abort}) begin
        errors++;
        $display("FAIL model_cmp t=%0t got cas=%0d oe=%b frz=%b isr=%b voe=%b lvl=%0d aeoi=%b abort=%b expected cas=%0d oe=%b frz=%b isr=%b voe=%b lvl=%0d aeoi=%b abort=%b",
                 $time, CAS_out, CAS_oe, freeze, isr_set, vec_oe, vec_level, aeoi_clr, abort,
                 m_cas, m_cas_oe, m_freeze, m_isr, m_vec_oe, m_lvl, m_aeoi, m_abort);
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Apply one INTAn sample and wait until the DUT has reacted to it.
  task automatic drive(input logic v);
    INTAn = v;
    if (rnd_en) begin
      int_pend  = ($urandom_range(3) != 0);
      irq_level = 3'($urandom);
      CAS_in    = ($urandom_range(1) == 1) ? slave_id : 3'($urandom);
    end
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_freeze"}, freeze, 1'b0);
    check1({tag, "_isr_set"}, isr_set, 1'b0);
    check1({tag, "_cas_oe"}, CAS_oe, 1'b0);
    check1({tag, "_vec_oe"}, vec_oe, 1'b0);
    check1({tag, "_aeoi_clr"}, aeoi_clr, 1'b0);
    check1({tag, "_abort"}, abort, 1'b0);
    check3({tag, "_vec_level"}, vec_level, 3'd0);
    check3({tag, "_cas_out"}, CAS_out, 3'd0);
  endtask

  task automatic rand_ack();
    int gap;
    buff     = 1'($urandom);
    MS       = 1'($urandom);
    SPENn    = 1'($urandom);
    sngl     = ($urandom_range(3) == 0);
    icw3_m   = 8'($urandom);
    slave_id = 3'($urandom);
    aeoi     = 1'($urandom);
    repeat ($urandom_range(3, 1)) drive(1'b0);
    gap = ($urandom_range(19) == 0) ? 70 : int'($urandom_range(5, 1));
    repeat (gap) drive(1'b1);
    repeat ($urandom_range(3, 1)) drive(1'b0);
    repeat ($urandom_range(4, 1)) drive(1'b1);
  endtask

  initial begin
    RSTn = 1'b0; INTAn = 1'b1; SPENn = 1'b1; buff = 1'b0; MS = 1'b0;
    sngl = 1'b0; int_pend = 1'b0; aeoi = 1'b0; icw3_m = 8'h00;
    slave_id = 3'd0; irq_level = 3'd0; CAS_in = 3'd0;
    tick(); tick();
    check_all_zero("reset");
    RSTn = 1'b1; cmp_en = 1'b1;
    tick();

    // Master with IR2 routed to a slave.
    sngl = 1'b0; icw3_m = 8'h04; irq_level = 3'd2; int_pend = 1'b1;
    drive(1'b0);
    check1("m_ack1_isr", isr_set, 1'b1);
    check3("m_ack1_cas", CAS_out, 3'd2);
    check1("m_ack1_cas_oe", CAS_oe, 1'b1);
    check1("m_ack1_freeze", freeze, 1'b1);
    check3("m_ack1_lvl", vec_level, 3'd2);
    drive(1'b0);
    check1("m_isr_one_cycle", isr_set, 1'b0);
    drive(1'b1); drive(1'b1);
    check1("m_gap_cas_oe", CAS_oe, 1'b1);
    drive(1'b0);
    check1("m_ack2_vec_oe", vec_oe, 1'b0);
    check1("m_ack2_cas_oe", CAS_oe, 1'b1);
    drive(1'b1);
    check1("m_end_cas_oe", CAS_oe, 1'b0);
    check1("m_end_freeze", freeze, 1'b0);
    check3("m_end_cas_hold", CAS_out, 3'd2);

    // Master in single mode.
    sngl = 1'b1; irq_level = 3'd5;
    drive(1'b1); drive(1'b0);
    check1("sngl_cas_oe", CAS_oe, 1'b0);
    check3("sngl_lvl", vec_level, 3'd5);
    check1("sngl_ack1_vec_oe", vec_oe, 1'b0);
    drive(1'b1); drive(1'b0);
    check1("sngl_ack2_vec_oe", vec_oe, 1'b1);
    drive(1'b1);
    check1("sngl_end_vec_oe", vec_oe, 1'b0);

    // Slave selected, then not selected.
    SPENn = 1'b0; sngl = 1'b0; slave_id = 3'd3; irq_level = 3'd6; CAS_in = 3'd3;
    drive(1'b0);
    check1("slv_ack1_isr", isr_set, 1'b0);
    drive(1'b1); drive(1'b0);
    check1("slv_hit_isr", isr_set, 1'b1);
    check1("slv_hit_vec_oe", vec_oe, 1'b1);
    drive(1'b1);
    CAS_in = 3'd1;
    drive(1'b0); drive(1'b1); drive(1'b0);
    check1("slv_miss_isr", isr_set, 1'b0);
    check1("slv_miss_vec_oe", vec_oe, 1'b0);
    drive(1'b1);

    // Spurious acknowledge.
    SPENn = 1'b1; sngl = 1'b1; int_pend = 1'b0; aeoi = 1'b1;
    drive(1'b0);
    check3("spur_lvl", vec_level, 3'd7);
    check1("spur_isr", isr_set, 1'b0);
    drive(1'b1); drive(1'b0);
    check1("spur_vec_oe", vec_oe, 1'b1);
    drive(1'b1);
    check1("spur_aeoi", aeoi_clr, 1'b0);

    // GAP watchdog: 64 cycles without the second pulse.
    int_pend = 1'b1; aeoi = 1'b0;
    drive(1'b0); drive(1'b1);
    repeat (TIMEOUT - 1) drive(1'b1);
    check1("wd_before_abort", abort, 1'b0);
    check1("wd_before_freeze", freeze, 1'b1);
    drive(1'b1);
    check1("wd_abort", abort, 1'b1);
    check1("wd_freeze", freeze, 1'b0);
    drive(1'b1);
    check1("wd_abort_one_cycle", abort, 1'b0);
    drive(1'b0);
    check1("wd_idle_new_ack", isr_set, 1'b1);
    drive(1'b1); drive(1'b0); drive(1'b1);

    // AEOI, then reset in the middle of ACK2.
    aeoi = 1'b1; irq_level = 3'd4;
    drive(1'b0); drive(1'b1); drive(1'b0); drive(1'b1);
    check1("aeoi_pulse", aeoi_clr, 1'b1);
    check1("aeoi_vec_oe", vec_oe, 1'b0);
    drive(1'b1);
    check1("aeoi_one_cycle", aeoi_clr, 1'b0);
    drive(1'b0); drive(1'b1); drive(1'b0);
    check1("pre_rst_vec_oe", vec_oe, 1'b1);
    #2 RSTn = 1'b0;
    #1 check_all_zero("async_rst");
    INTAn = 1'b1;
    tick();
    RSTn = 1'b1;
    tick();

    // Randomized acknowledges, then free-running INTAn.
    rnd_en = 1'b1;
    repeat (300) rand_ack();
    repeat (400) drive(1'($urandom));
    repeat (4) drive(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
